// File: rtl/gen_lane_valid_ctrl.sv
// PCIe MAC generation/link-width controller with change-drain sequencing.
// Optional GEN_CTRL_CFG_ERR_EN adds sticky cfg_err and saturating cfg_err_cnt.
module gen_lane_valid_ctrl #(
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 16,
    parameter int GEN3_PIPEWIDTH = 32,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8,
    parameter int MAX_LANES      = 16,
    parameter int VALID_W        = 64,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic               pclk,
    input  logic               reset_n,
    input  logic               valid_pd,
    input  logic               linkup,
    input  logic [2:0]         gen,
    input  logic [4:0]         numberOfDetectedLanes,
    output logic               sel,
    output logic [VALID_W-1:0] valid,
    output logic               w,
    output logic               cfg_stable,
    output logic [7:0]         bytes_per_cycle
`ifdef GEN_CTRL_CFG_ERR_EN
    ,
    output logic               cfg_err,
    output logic [7:0]         cfg_err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        ACTIVE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [2:0]         gen_q, gen_d;
    logic [4:0]         lanes_q, lanes_d;
    logic               sel_d;
    logic [7:0]         bpc_d;
    logic               w_d;
    logic [VALID_W-1:0] valid_d;
    logic               chg;
    logic               latch;
    logic [7:0]         cur_bytes;

    // A zero byte count doubles as the "illegal configuration" marker.
    function automatic logic [7:0] cfg_bytes(
        input logic [2:0] g,
        input logic [4:0] l
    );
        int bpl;
        int n;
        int t;
        case (g)
            3'd1:    bpl = GEN1_PIPEWIDTH / 8;
            3'd2:    bpl = GEN2_PIPEWIDTH / 8;
            3'd3:    bpl = GEN3_PIPEWIDTH / 8;
            3'd4:    bpl = GEN4_PIPEWIDTH / 8;
            3'd5:    bpl = GEN5_PIPEWIDTH / 8;
            default: bpl = 0;
        endcase
        case (l)
            5'b00001: n = 1;
            5'b00010: n = 2;
            5'b00100: n = 4;
            5'b01000: n = 8;
            5'b10000: n = 16;
            default:  n = 0;
        endcase
        t = bpl * n;
        if (n > MAX_LANES || t > VALID_W) t = 0;
        return 8'(t);
    endfunction

    assign cur_bytes = cfg_bytes(gen, numberOfDetectedLanes);
    assign chg = (gen != gen_q) || (numberOfDetectedLanes != lanes_q);

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            gen_q           <= '0;
            lanes_q         <= '0;
            sel             <= 1'b0;
            bytes_per_cycle <= '0;
            w               <= 1'b0;
            valid           <= '0;
            cfg_stable      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            gen_q           <= gen_d;
            lanes_q         <= lanes_d;
            sel             <= sel_d;
            bytes_per_cycle <= bpc_d;
            w               <= w_d;
            valid           <= valid_d;
            cfg_stable      <= (state_d == ACTIVE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gen_d   = gen_q;
        lanes_d = lanes_q;
        sel_d   = sel;
        bpc_d   = bytes_per_cycle;
        w_d     = 1'b0;
        latch   = 1'b0;
        valid_d = '0;
        if (!linkup) begin
            state_d = IDLE;
            gen_d   = '0;
            lanes_d = '0;
            sel_d   = 1'b0;
            bpc_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    latch   = 1'b1;
                    state_d = DRAIN;
                end
                DRAIN: begin
                    if (chg) latch = 1'b1;
                    else if (cnt_q == 8'd1) state_d = ACTIVE;
                    else cnt_d = cnt_q - 8'd1;
                end
                ACTIVE: begin
                    if (chg) begin
                        latch   = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        w_d = valid_pd && (bytes_per_cycle != 8'd0);
                    end
                end
                default: state_d = IDLE;
            endcase
            if (latch) begin
                gen_d   = gen;
                lanes_d = numberOfDetectedLanes;
                cnt_d   = 8'(DRAIN_CYCLES);
                sel_d   = (gen >= 3'd3);
                bpc_d   = cur_bytes;
            end
        end
        for (int i = 0; i < VALID_W; i++) begin
            valid_d[i] = w_d && (i < int'(bytes_per_cycle));
        end
    end

`ifdef GEN_CTRL_CFG_ERR_EN
    logic illegal;
    assign illegal = linkup && (cur_bytes == 8'd0);

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err     <= 1'b0;
            cfg_err_cnt <= '0;
        end else if (illegal) begin
            cfg_err <= 1'b1;
            if (cfg_err_cnt != 8'hFF) cfg_err_cnt <= cfg_err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gen_lane_valid_ctrl.sv
// Directed table-driven bench for gen_lane_valid_ctrl (DRAIN_CYCLES = 4).
module tb_gen_lane_valid_ctrl;

    logic        pclk = 1'b0;
    logic        reset_n;
    logic        valid_pd;
    logic        linkup;
    logic [2:0]  gen;
    logic [4:0]  lanes;
    logic        sel;
    logic [63:0] valid;
    logic        w;
    logic        cfg_stable;
    logic [7:0]  bpc;
`ifdef GEN_CTRL_CFG_ERR_EN
    logic        cfg_err;
    logic [7:0]  cfg_err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    gen_lane_valid_ctrl dut (
        .pclk                  (pclk),
        .reset_n               (reset_n),
        .valid_pd              (valid_pd),
        .linkup                (linkup),
        .gen                   (gen),
        .numberOfDetectedLanes (lanes),
        .sel                   (sel),
        .valid                 (valid),
        .w                     (w),
        .cfg_stable            (cfg_stable),
        .bytes_per_cycle       (bpc)
`ifdef GEN_CTRL_CFG_ERR_EN
        ,
        .cfg_err               (cfg_err),
        .cfg_err_cnt           (cfg_err_cnt)
`endif
    );

    typedef struct {
        logic        vp;
        logic        lk;
        logic [2:0]  g;
        logic [4:0]  l;
        logic        ew;
        logic [63:0] ev;
        logic        es;
        logic [7:0]  eb;
        logic        ec;
    } vec_t;

    vec_t tbl[$];

    localparam logic [63:0] M16 = 64'h0000_0000_0000_FFFF;
    localparam logic [63:0] MALL = '1;

    function automatic vec_t mk(
        input logic vp, input logic lk, input logic [2:0] g,
        input logic [4:0] l, input logic ew, input logic [63:0] ev,
        input logic es, input logic [7:0] eb, input logic ec
    );
        vec_t v;
        v.vp = vp; v.lk = lk; v.g = g; v.l = l;
        v.ew = ew; v.ev = ev; v.es = es; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vp, input logic lk,
                         input logic [2:0] g, input logic [4:0] l);
        valid_pd = vp;
        linkup   = lk;
        gen      = g;
        lanes    = l;
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ew,
                           input logic [63:0] ev, input logic es,
                           input logic [7:0] eb, input logic ec);
        chk({tag, ".w"}, 64'(w), 64'(ew));
        chk({tag, ".valid"}, valid, ev);
        chk({tag, ".sel"}, 64'(sel), 64'(es));
        chk({tag, ".bpc"}, 64'(bpc), 64'(eb));
        chk({tag, ".cfg_stable"}, 64'(cfg_stable), 64'(ec));
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 3'd0, 5'd0);
        repeat (3) step();
        chk_all("reset", 0, 0, 0, 0, 0);
`ifdef GEN_CTRL_CFG_ERR_EN
        chk("reset.cfg_err", 64'(cfg_err), 0);
        chk("reset.cfg_err_cnt", 64'(cfg_err_cnt), 0);
`endif
        reset_n = 1'b1;

        // bring-up gen1 x16
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 3'd1, 5'b10000, 0, 0, 0, 8'd16, 0));
        tbl.push_back(mk(1, 1, 3'd1, 5'b10000, 0, 0, 0, 8'd16, 1));
        tbl.push_back(mk(1, 1, 3'd1, 5'b10000, 1, M16, 0, 8'd16, 1));
        // gen3 x16
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 3'd3, 5'b10000, 0, 0, 1, 8'd64, 0));
        tbl.push_back(mk(1, 1, 3'd3, 5'b10000, 0, 0, 1, 8'd64, 1));
        tbl.push_back(mk(1, 1, 3'd3, 5'b10000, 1, MALL, 1, 8'd64, 1));
        // gen3 x4
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 3'd3, 5'b00100, 0, 0, 1, 8'd16, 0));
        tbl.push_back(mk(1, 1, 3'd3, 5'b00100, 0, 0, 1, 8'd16, 1));
        tbl.push_back(mk(1, 1, 3'd3, 5'b00100, 1, M16, 1, 8'd16, 1));
        tbl.push_back(mk(0, 1, 3'd3, 5'b00100, 0, 0, 1, 8'd16, 1));
        tbl.push_back(mk(1, 1, 3'd3, 5'b00100, 1, M16, 1, 8'd16, 1));
        // gen2 x8, then gen5 while counter is 2
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1, 3'd2, 5'b01000, 0, 0, 0, 8'd16, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 3'd5, 5'b01000, 0, 0, 1, 8'd8, 0));
        tbl.push_back(mk(1, 1, 3'd5, 5'b01000, 0, 0, 1, 8'd8, 1));
        tbl.push_back(mk(1, 1, 3'd5, 5'b01000, 1, 64'hFF, 1, 8'd8, 1));

        foreach (tbl[k]) begin
            drive(tbl[k].vp, tbl[k].lk, tbl[k].g, tbl[k].l);
            step();
            chk_all($sformatf("vec%0d", k), tbl[k].ew, tbl[k].ev,
                    tbl[k].es, tbl[k].eb, tbl[k].ec);
        end

        // linkup drop coincident with gen change
        drive(1, 0, 3'd3, 5'b01000);
        step();
        chk_all("drop", 0, 0, 0, 0, 0);
        step();
        chk_all("idle", 0, 0, 0, 0, 0);
        drive(1, 1, 3'd1, 5'b00001);
        step();
        chk_all("relink", 0, 0, 0, 8'd1, 0);
        repeat (3) step();
        chk("relink.drain_cs", 64'(cfg_stable), 0);
        step();
        chk("relink.active_cs", 64'(cfg_stable), 1);
        step();
        chk_all("relink.data", 1, 64'h1, 0, 8'd1, 1);

        // asynchronous reset while ACTIVE
        @(posedge pclk);
        #2 reset_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        #3 reset_n = 1'b1;
        step();
        chk_all("post_rst", 0, 0, 0, 8'd1, 0);
        repeat (3) step();
        chk("post_rst.drain_cs", 64'(cfg_stable), 0);
        step();
        chk("post_rst.active_cs", 64'(cfg_stable), 1);

        // illegal configurations
        drive(1, 1, 3'd3, 5'b00011);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("ill_lanes%0d.w", i), 64'(w), 0);
            chk($sformatf("ill_lanes%0d.valid", i), valid, 0);
        end
        chk("ill_lanes.bpc", 64'(bpc), 0);
        chk("ill_lanes.cs", 64'(cfg_stable), 1);
        drive(1, 1, 3'd7, 5'b00100);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("ill_gen%0d.w", i), 64'(w), 0);
            chk($sformatf("ill_gen%0d.valid", i), valid, 0);
        end
        chk("ill_gen.bpc", 64'(bpc), 0);
`ifdef GEN_CTRL_CFG_ERR_EN
        chk("cfg_err", 64'(cfg_err), 1);
        chk("cfg_err_cnt16", 64'(cfg_err_cnt), 16);
        repeat (260) step();
        chk("cfg_err_cnt_sat", 64'(cfg_err_cnt), 255);
        drive(1, 1, 3'd1, 5'b00001);
        repeat (3) step();
        chk("cfg_err_sticky", 64'(cfg_err), 1);
        chk("cfg_err_cnt_hold", 64'(cfg_err_cnt), 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_lane_valid_ctrl.md
Name: gen_lane_valid_ctrl

Overview:
- Registered, parametrised generation/link-width controller for the PCIe MAC datapath.
- Decodes the negotiated generation (1..5) and detected lane count (x1/x2/x4/x8/x16) into a per-byte valid mask, a datapath-width select and a write strobe for the downstream PIPE-side buffers.
- Adds a change-drain state machine: when rate or width changes, the datapath is quiesced for a programmable number of cycles before the new mask is applied.

Parameters:
GEN1_PIPEWIDTH, 8, PIPE data width per lane in Gen1 (bits)
GEN2_PIPEWIDTH, 16, PIPE data width per lane in Gen2 (bits)
GEN3_PIPEWIDTH, 32, PIPE data width per lane in Gen3 (bits)
GEN4_PIPEWIDTH, 8, PIPE data width per lane in Gen4 (bits)
GEN5_PIPEWIDTH, 8, PIPE data width per lane in Gen5 (bits)
MAX_LANES, 16, maximum link width; power of two, 1..16
VALID_W, 64, width of valid mask in bytes; must be at least max(GENx_PIPEWIDTH)/8*MAX_LANES
DRAIN_CYCLES, 4, cycles the valid mask is forced to 0 after a config change; 1..255

Ports:
pclk  input  1  datapath clock
reset_n  input  1  asynchronous active-low reset
valid_pd  input  1  upstream data valid
linkup  input  1  link is up (LTSSM L0)
gen  input  3  current generation, 1..5
numberOfDetectedLanes  input  5  one-hot lane count (00001=x1 .. 10000=x16)
sel  output  1  0 = Gen1/Gen2 narrow path, 1 = Gen3+ path
valid  output  VALID_W  per-byte valid mask
w  output  1  write strobe to downstream buffer
cfg_stable  output  1  1 when in ACTIVE state
bytes_per_cycle  output  8  number of valid bytes in the applied mask

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Latched gen and lanes are 0.
- Mask decode: mask = (GENx_PIPEWIDTH/8)*lanes low-order ones, upper bits 0.
- Illegal configurations produce a mask of 0 and bytes_per_cycle = 0:
  - gen not in 1..5;
  - lanes not one-hot;
  - lanes > MAX_LANES;
  - byte count > VALID_W.
- States: IDLE, DRAIN, ACTIVE.
- IDLE:
  - On linkup=1, latch gen/lanes, load the counter with DRAIN_CYCLES and go to DRAIN.
- DRAIN:
  - Counter decrements each cycle.
  - If gen or lanes differ from the latched value, re-latch and reload the counter (restart).
  - When the counter reaches 1 with no change, go to ACTIVE.
- ACTIVE:
  - Any change in gen/lanes versus the latched value: re-latch, reload the counter, go to DRAIN. valid/w are 0 from the next cycle.
- linkup=0 in any state: go to IDLE next cycle and clear the latch. valid, w and cfg_stable are 0 in that same next cycle.
- Registered outputs, 1-cycle latency:
  - w(t+1) = valid_pd(t) & linkup(t) & (state(t)==ACTIVE) & (no cfg change at t).
  - valid(t+1) = w(t+1) ? applied_mask : 0.
- sel and bytes_per_cycle are registered from the latched gen/lanes:
  - sel = 0 for gen 1/2, else 1.
  - Both update on every latch event, including during DRAIN.
  - Both hold their value in ACTIVE.
  - In IDLE, sel = 0 and bytes_per_cycle = 0.
- cfg_stable is 1 exactly when the state is ACTIVE (registered).
- Simultaneous linkup fall and config change: linkup has priority (go to IDLE).
- Reset mid-DRAIN/ACTIVE: immediate return to reset values (asynchronous); restart from IDLE on deassertion.

Optional Feature:
- Macro: GEN_CTRL_CFG_ERR_EN.
- When defined, add two outputs:
  - cfg_err (1 bit): sticky, cleared only by reset. Set when linkup=1 and the sampled gen/lanes are illegal.
  - cfg_err_cnt (8 bits): saturating at 255; increments on each such cycle.
- An illegal configuration in ACTIVE still forces valid=0 and w=0.
- When not defined, neither port exists. Illegal configurations silently yield a 0 mask.

Test Plan:
- Reset, then linkup=1, gen=1, lanes=10000, valid_pd=1 held:
  - cfg_stable=1 after 1+DRAIN_CYCLES cycles.
  - Next cycle valid=64'h0000_0000_0000_FFFF, w=1, sel=0, bytes_per_cycle=16.
- ACTIVE gen=3 x16: valid=all ones (64 bytes), sel=1, bytes_per_cycle=64. Then switch lanes to x4:
  - valid=0, w=0 for DRAIN_CYCLES cycles.
  - Then valid=64'h0000_0000_0000_FFFF, bytes_per_cycle=16.
- During DRAIN, change gen 2→5 at counter=2: counter reloads and the full DRAIN_CYCLES elapse. Final mask for x8 Gen5 = 64'hFF.
- ACTIVE with valid_pd toggling 1,0,1: w and valid follow with exactly 1-cycle latency. valid=0 whenever w=0.
- linkup drops in ACTIVE at the same cycle gen changes: next cycle IDLE, all outputs 0, sel=0. Re-raising linkup restarts DRAIN.
- lanes=00011 or gen=7 with linkup=1: valid stays 0, no w. With GEN_CTRL_CFG_ERR_EN, cfg_err=1 and cfg_err_cnt counts cycles, saturating at 255.
